multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 218 +++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: control unit for a multi-cycle RV32 subset core.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK), owns pc and
// the instruction register, and traps on any unsupported encoding.
//
// Build option: define MUL_EN to accept R-type MUL (func7=0000001, func3=000)
// as a regular ALU op with alu_op=010; otherwise that encoding traps.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   mem_ready           completes the current memory request
//   mem_rdata[31:0]     instruction word, valid with mem_ready during fetch
//   alu_zero            ALU result is zero (branch compare)
//   alu_result[XLEN]    ALU output, JALR target source
//   mem_req/mem_we/mem_fetch  memory request, write strobe, fetch qualifier
//   pc[XLEN], ins[31:0], imm[XLEN]  program counter, instruction reg, immediate
//   alu_src, alu_op[2:0], reg_write, mem_to_reg, pc_to_reg  datapath controls
//   illegal             sticky trap flag
//   retire              one-cycle pulse, coincident with each pc update
// All outputs are registered.
module multi_cycle_control #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] alu_result,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_fetch,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     ins,
    output logic [XLEN-1:0] imm,
    output logic            alu_src,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            pc_to_reg,
    output logic [2:0]      alu_op,
    output logic            illegal,
    output logic            retire
);

    localparam logic [31:0] INS_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} state_t;
    typedef enum logic [2:0] {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

    state_t          state, state_d;
    kind_t           kind;
    logic [31:0]     ins_d;
    logic [XLEN-1:0] pc_d, target, target_d, imm_dec, imm_d;
    logic [2:0]      op_dec, alu_op_d;
    logic            src_dec, active;
    logic            mem_req_d, mem_we_d, mem_fetch_d, alu_src_d, reg_write_d;
    logic            mem_to_reg_d, pc_to_reg_d, illegal_d, retire_d;

    // Instruction register next value: decode always looks at the word that
    // will be in ins next cycle, so DECODE-cycle outputs come out registered.
    always_comb begin
        ins_d = ins;
        if (state == FETCH && mem_ready) ins_d = mem_rdata;
    end

    // Instruction classification, ALU controls and immediate extraction.
    always_comb begin
        kind    = K_ILL;
        op_dec  = 3'b000;
        src_dec = 1'b0;
        imm_dec = '0;
        case (ins_d[6:0])
            7'b0110011: begin
                case ({ins_d[31:25], ins_d[14:12]})
                    {7'b0000000, 3'b000}: begin kind = K_R; op_dec = 3'b000; end
                    {7'b0100000, 3'b000}: begin kind = K_R; op_dec = 3'b001; end
                    {7'b0000000, 3'b111}: begin kind = K_R; op_dec = 3'b011; end
                    {7'b0000000, 3'b110}: begin kind = K_R; op_dec = 3'b100; end
                    {7'b0000000, 3'b001}: begin kind = K_R; op_dec = 3'b101; end
`ifdef MUL_EN
                    {7'b0000001, 3'b000}: begin kind = K_R; op_dec = 3'b010; end
`endif
                    default: kind = K_ILL;
                endcase
            end
            7'b0010011: begin
                if (ins_d[14:12] == 3'b000) begin
                    kind = K_I; op_dec = 3'b000; src_dec = 1'b1;
                end else if (ins_d[14:12] == 3'b001 && ins_d[31:25] == 7'b0000000) begin
                    kind = K_I; op_dec = 3'b101; src_dec = 1'b1;
                end
            end
            7'b0000011: if (ins_d[14:12] == 3'b010) begin kind = K_LW; src_dec = 1'b1; end
            7'b0100011: if (ins_d[14:12] == 3'b010) begin kind = K_SW; src_dec = 1'b1; end
            7'b1100011: if (ins_d[14:13] == 2'b00) begin kind = K_BR; op_dec = 3'b001; end
            7'b1101111: kind = K_JAL;
            7'b1100111: if (ins_d[14:12] == 3'b000) begin kind = K_JALR; src_dec = 1'b1; end
            default:    kind = K_ILL;
        endcase

        case (kind)
            K_I, K_LW, K_JALR:
                imm_dec = {{(XLEN-12){ins_d[31]}}, ins_d[31:20]};
            K_SW:
                imm_dec = {{(XLEN-12){ins_d[31]}}, ins_d[31:25], ins_d[11:7]};
            K_BR:
                imm_dec = {{(XLEN-13){ins_d[31]}}, ins_d[31], ins_d[7], ins_d[30:25],
                           ins_d[11:8], 1'b0};
            K_JAL:
                imm_dec = {{(XLEN-21){ins_d[31]}}, ins_d[31], ins_d[19:12], ins_d[20],
                           ins_d[30:21], 1'b0};
            default:
                imm_dec = '0;
        endcase
    end

    // Next state, pc/target updates, and registered outputs for the next state.
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        target_d = target;
        retire_d = 1'b0;
        case (state)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE:  state_d = (kind == K_ILL) ? TRAP : EXECUTE;
            EXECUTE: begin
                case (kind)
                    K_LW, K_SW: state_d = MEM;
                    K_BR: begin
                        // ins[12] distinguishes BNE from BEQ
                        state_d  = FETCH;
                        retire_d = 1'b1;
                        pc_d     = (ins[12] ^ alu_zero) ? pc + imm : pc + XLEN'(4);
                    end
                    K_JALR: begin
                        target_d = alu_result & ~XLEN'(1);
                        state_d  = WRITEBACK;
                    end
                    default: state_d = WRITEBACK;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (kind == K_SW) begin
                        state_d  = FETCH;
                        pc_d     = pc + XLEN'(4);
                        retire_d = 1'b1;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                state_d  = FETCH;
                retire_d = 1'b1;
                case (kind)
                    K_JAL:   pc_d = pc + imm;
                    K_JALR:  pc_d = target;
                    default: pc_d = pc + XLEN'(4);
                endcase
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // ALU controls and imm are held for the whole instruction body
        active       = (state_d == DECODE) || (state_d == EXECUTE) ||
                       (state_d == MEM) || (state_d == WRITEBACK);
        mem_req_d    = (state_d == FETCH) || (state_d == MEM);
        mem_fetch_d  = (state_d == FETCH);
        mem_we_d     = (state_d == MEM) && (kind == K_SW);
        reg_write_d  = (state_d == WRITEBACK);
        mem_to_reg_d = (state_d == WRITEBACK) && (kind == K_LW);
        pc_to_reg_d  = (state_d == WRITEBACK) && (kind == K_JAL || kind == K_JALR);
        illegal_d    = (state_d == TRAP);
        alu_op_d     = active ? op_dec : 3'b000;
        alu_src_d    = active && src_dec;
        imm_d        = active ? imm_dec : '0;
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ins        <= INS_NOP;
            target     <= '0;
            imm        <= '0;
            mem_req    <= 1'b1;
            mem_fetch  <= 1'b1;
            mem_we     <= 1'b0;
            alu_src    <= 1'b0;
            alu_op     <= 3'b000;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            pc_to_reg  <= 1'b0;
            illegal    <= 1'b0;
            retire     <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            ins        <= ins_d;
            target     <= target_d;
            imm        <= imm_d;
            mem_req    <= mem_req_d;
            mem_fetch  <= mem_fetch_d;
            mem_we     <= mem_we_d;
            alu_src    <= alu_src_d;
            alu_op     <= alu_op_d;
            reg_write  <= reg_write_d;
            mem_to_reg <= mem_to_reg_d;
            pc_to_reg  <= pc_to_reg_d;
            illegal    <= illegal_d;
            retire     <= retire_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: directed instruction sequences against an
// instruction-level model that emits the expected per-cycle output trace.
module tb_multi_cycle_control;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        mem_fetch;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] imm;
        logic        alu_src;
        logic        reg_write;
        logic        mem_to_reg;
        logic        pc_to_reg;
        logic [2:0]  alu_op;
        logic        illegal;
        logic        retire;
    } obs_t;

    typedef enum int {C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_JAL, C_JALR} cls_t;

    typedef struct {
        logic        legal;
        cls_t        cls;
        logic [2:0]  op;
        logic        src;
        logic [31:0] imm;
    } dec_t;

    logic            clk, rst_n, mem_ready, alu_zero;
    logic [31:0]     mem_rdata;
    logic [XLEN-1:0] alu_result, pc, imm;
    logic [31:0]     ins;
    logic            mem_req, mem_we, mem_fetch, alu_src, reg_write;
    logic            mem_to_reg, pc_to_reg, illegal, retire;
    logic [2:0]      alu_op;

    obs_t            act, exp_o;
    logic            exp_valid;
    int              n_cmp, n_bad;

    logic [31:0]     m_pc, m_ins;
    logic            m_ret;
    logic [31:0]     imm_seen;
    logic [2:0]      op_seen;
    logic            ill_seen, req_seen;

    multi_cycle_control #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .alu_zero(alu_zero), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_fetch(mem_fetch),
        .pc(pc), .ins(ins), .imm(imm), .alu_src(alu_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .alu_op(alu_op),
        .illegal(illegal), .retire(retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {mem_req, mem_we, mem_fetch, pc, ins, imm, alu_src, reg_write,
                  mem_to_reg, pc_to_reg, alu_op, illegal, retire};

    // Per-cycle comparison against the model's expected trace.
    always @(negedge clk) begin
        if (exp_valid) begin
            n_cmp++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL cycle @%0t: got %h want %h (pc got %h want %h, ins got %h want %h)",
                         $time, act, exp_o, act.pc, exp_o.pc, act.ins, exp_o.ins);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Instruction-set view of the supported encodings.
    function automatic dec_t mdecode(input logic [31:0] w);
        dec_t        d;
        int          vi, vs, vb, vj;
        logic [16:0] key;
        vi = int'(w[31:20]) - (w[31] ? 4096 : 0);
        vs = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
        vb = int'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? 8192 : 0);
        vj = int'({w[31], w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? 2097152 : 0);
        d.legal = 1'b1; d.cls = C_ALU; d.op = 3'b000; d.src = 1'b0; d.imm = '0;
        key = {w[31:25], w[14:12], w[6:0]};
        casez (key)
            17'b0000000_000_0110011: d.op = 3'b000;
            17'b0100000_000_0110011: d.op = 3'b001;
            17'b0000000_111_0110011: d.op = 3'b011;
            17'b0000000_110_0110011: d.op = 3'b100;
            17'b0000000_001_0110011: d.op = 3'b101;
`ifdef MUL_EN
            17'b0000001_000_0110011: d.op = 3'b010;
`endif
            17'b???????_000_0010011: begin d.src = 1'b1; d.imm = 32'(vi); end
            17'b0000000_001_0010011: begin d.src = 1'b1; d.op = 3'b101; d.imm = 32'(vi); end
            17'b???????_010_0000011: begin d.cls = C_LW; d.src = 1'b1; d.imm = 32'(vi); end
            17'b???????_010_0100011: begin d.cls = C_SW; d.src = 1'b1; d.imm = 32'(vs); end
            17'b???????_000_1100011: begin d.cls = C_BEQ; d.op = 3'b001; d.imm = 32'(vb); end
            17'b???????_001_1100011: begin d.cls = C_BNE; d.op = 3'b001; d.imm = 32'(vb); end
            17'b???????_???_1101111: begin d.cls = C_JAL; d.imm = 32'(vj); end
            17'b???????_000_1100111: begin d.cls = C_JALR; d.src = 1'b1; d.imm = 32'(vi); end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic obs_t base();
        obs_t e;
        e     = '0;
        e.pc  = m_pc;
        e.ins = m_ins;
        return e;
    endfunction

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_ins = NOP;
        m_ret = 1'b0;
    endtask

    // One clock cycle: drive inputs, publish the expectation for this cycle.
    task automatic cyc(input logic rst, input logic rdy, input logic az,
                       input logic [31:0] ar, input obs_t e);
        rst_n      = rst;
        mem_ready  = rdy;
        alu_zero   = az;
        alu_result = ar;
        exp_o      = e;
        exp_valid  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Run one instruction: fw fetch waits, mw memory waits, optional reset
    // asserted at MEM cycle rst_mem (-1 for none). Illegal words trap for a
    // few cycles and are then cleared by a one-cycle reset.
    task automatic instr(input logic [31:0] w, input int fw, input int mw, input logic az,
                         input logic [31:0] ar, input int rst_mem);
        dec_t   d;
        obs_t   e, x;
        logic   aborted, taken;
        d = mdecode(w);
        mem_rdata = w;
        for (int i = 0; i <= fw; i++) begin
            e = base(); e.mem_req = 1'b1; e.mem_fetch = 1'b1;
            e.retire = (i == 0) ? m_ret : 1'b0;
            cyc(1'b1, (i == fw), 1'b0, '0, e);
        end
        m_ret = 1'b0;
        m_ins = w;
        imm_seen = imm;
        op_seen  = alu_op;
        x = base(); x.imm = d.imm; x.alu_op = d.op; x.alu_src = d.src;
        cyc(1'b1, 1'b0, 1'b0, '0, x);
        ill_seen = illegal;
        req_seen = mem_req;
        if (!d.legal) begin
            for (int i = 0; i < 4; i++) begin
                e = base(); e.illegal = 1'b1;
                cyc((i != 3), 1'b1, 1'b0, '0, e);
            end
            model_reset();
        end else begin
            cyc(1'b1, 1'b0, az, ar, x);
            aborted = 1'b0;
            case (d.cls)
                C_BEQ, C_BNE: begin
                    taken = (d.cls == C_BEQ) ? az : !az;
                    m_pc  = taken ? m_pc + d.imm : m_pc + 32'd4;
                    m_ret = 1'b1;
                end
                C_LW, C_SW: begin
                    for (int i = 0; i <= mw; i++) begin
                        if (!aborted) begin
                            e = x; e.mem_req = 1'b1; e.mem_we = (d.cls == C_SW);
                            if (i == rst_mem) begin
                                cyc(1'b0, 1'b1, 1'b0, '0, e);
                                aborted = 1'b1;
                            end else begin
                                cyc(1'b1, (i == mw), 1'b0, '0, e);
                            end
                        end
                    end
                    if (aborted) model_reset();
                    else if (d.cls == C_SW) begin
                        m_pc  = m_pc + 32'd4;
                        m_ret = 1'b1;
                    end
                end
                default: ;
            endcase
            if (!aborted && d.cls != C_BEQ && d.cls != C_BNE && d.cls != C_SW) begin
                e = x; e.reg_write = 1'b1;
                e.mem_to_reg = (d.cls == C_LW);
                e.pc_to_reg  = (d.cls == C_JAL || d.cls == C_JALR);
                cyc(1'b1, 1'b0, 1'b0, '0, e);
                if (d.cls == C_JAL)       m_pc = m_pc + d.imm;
                else if (d.cls == C_JALR) m_pc = ar & 32'hFFFF_FFFE;
                else                      m_pc = m_pc + 32'd4;
                m_ret = 1'b1;
            end
        end
    endtask

    initial begin
        obs_t e;
        n_cmp = 0; n_bad = 0; exp_valid = 1'b0;
        rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        alu_zero = 1'b0; alu_result = '0;
        imm_seen = '0; op_seen = '0; ill_seen = 1'b0; req_seen = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        // Held in reset with mem_ready high: fetch strobes only, nothing loads.
        e = base(); e.mem_req = 1'b1; e.mem_fetch = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, '0, e);
        cyc(1'b0, 1'b1, 1'b0, '0, e);
        pin("reset ins", ins, NOP);
        pin("reset pc", pc, RESET_PC);

        instr(32'h0050_0093, 0, 0, 1'b0, '0, -1);      // ADDI x1,x0,5
        pin("addi imm", imm_seen, 32'd5);
        pin("addi alu_op", 32'(op_seen), 32'd0);
        pin("addi pc", pc, 32'h4);
        pin("addi retire", 32'(retire), 32'd1);
        instr(32'h0050_0093, 2, 0, 1'b0, '0, -1);      // pc -> 8
        instr(32'hFE00_0EE3, 0, 0, 1'b1, '0, -1);      // BEQ taken
        pin("beq imm", imm_seen, 32'hFFFF_FFFC);
        pin("beq taken pc", pc, 32'h4);
        instr(32'h0050_0093, 0, 0, 1'b0, '0, -1);      // pc -> 8
        instr(32'hFE00_0EE3, 0, 0, 1'b0, '0, -1);      // BEQ not taken
        pin("beq fall pc", pc, 32'hC);
        instr(32'h0011_2223, 1, 3, 1'b0, '0, -1);      // SW, 4 MEM cycles
        pin("sw imm", imm_seen, 32'd4);
        pin("sw pc", pc, 32'h10);
        instr(32'h0041_2083, 0, 1, 1'b0, '0, -1);      // LW
        instr(32'h0020_80B3, 0, 0, 1'b0, '0, -1);      // ADD
        instr(32'h4020_80B3, 0, 0, 1'b0, '0, -1);      // SUB
        pin("sub alu_op", 32'(op_seen), 32'd1);
        instr(32'h0020_F0B3, 0, 0, 1'b0, '0, -1);      // AND
        instr(32'h0020_E0B3, 0, 0, 1'b0, '0, -1);      // OR
        instr(32'h0020_90B3, 0, 0, 1'b0, '0, -1);      // SLL
        instr(32'h0030_9093, 0, 0, 1'b0, '0, -1);      // SLLI x1,x1,3
        pin("slli imm", imm_seen, 32'd3);
        pin("slli pc", pc, 32'h2C);
        instr(32'h0020_9463, 0, 0, 1'b0, '0, -1);      // BNE +8 taken
        pin("bne pc", pc, 32'h34);
        instr(32'h0080_00EF, 0, 0, 1'b0, '0, -1);      // JAL +8
        pin("jal pc", pc, 32'h3C);
        instr(32'h0000_80E7, 0, 0, 1'b0, 32'h0000_0123, -1);  // JALR
        pin("jalr pc", pc, 32'h0000_0122);

        instr(32'h0011_2223, 0, 3, 1'b0, '0, 1);       // SW, reset mid-MEM
        pin("mem reset pc", pc, RESET_PC);
        pin("mem reset we", 32'(mem_we), 32'd0);
        pin("mem reset illegal", 32'(illegal), 32'd0);

        instr(32'h0000_80E7, 0, 0, 1'b0, 32'hFFFF_FFFC, -1);  // pc -> top of space
        pin("jalr high pc", pc, 32'hFFFF_FFFC);
        instr(32'h0050_0093, 0, 0, 1'b0, '0, -1);      // wraps to 0
        pin("wrap pc", pc, 32'h0);

        instr(32'h0220_8033, 0, 0, 1'b0, '0, -1);      // MUL
`ifdef MUL_EN
        pin("mul alu_op", 32'(op_seen), 32'd2);
        pin("mul pc", pc, 32'h4);
`else
        pin("mul illegal", 32'(ill_seen), 32'd1);
        pin("mul trap mem_req", 32'(req_seen), 32'd0);
        pin("mul cleared", 32'(illegal), 32'd0);
`endif
        instr(32'h0000_0000, 0, 0, 1'b0, '0, -1);      // bad opcode traps
        pin("opcode illegal", 32'(ill_seen), 32'd1);
        pin("trap reset pc", pc, RESET_PC);
        instr(32'h0050_0093, 0, 0, 1'b0, '0, -1);      // recovers after reset
        pin("recover pc", pc, 32'h4);

        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
